deb_scan: RTL
=============

// Module: deb_scan
// PURPOSE
//  Time-multiplexed debounce scheduler for the icestick button inputs.
//  One prescaler and one compare/increment path are shared round-robin
//  among N_BTN active-low buttons, replacing one free-running deb per button.
//  Outputs debounced levels plus one-cycle press/release strobes for the
//  application logic.
// PARAMETERS
//  N_BTN          4      number of buttons scanned (1..16)
//  TICK_DIV       12000  clk cycles per sample tick (1 ms at 12 MHz); must be > N_BTN+1
//  MAX_BTN_COUNT  20     consecutive differing ticks needed to accept a new level (>=1)
// PORTS
//  clk      in   1      system clock, 12 MHz
//  nrst     in   1      asynchronous active-low reset
//  nbtn     in   N_BTN  raw button pins, active-low, asynchronous to clk
//  out      out  N_BTN  debounced level, 1 = pressed
//  press    out  N_BTN  1-cycle strobe when out[i] rises 0->1
//  release  out  N_BTN  1-cycle strobe when out[i] falls 1->0
//  busy     out  1      high while a scan is in progress
// BEHAVIOUR
//  Reset (async, nrst=0): out=0, press=0, release=0, busy=0, all per-button
//   counters=0, prescaler=0, scan index=0, FSM=IDLE, sync flops=0 (released).
//  Input sync: btn = ~nbtn through 2-flop synchronizer per bit; only
//   synchronized btn_s is used below (2-cycle input latency).
//  Prescaler: counts 0..TICK_DIV-1 then wraps; tick=1 for the single cycle
//   where count==TICK_DIV-1. Free-running, not gated by FSM.
//  FSM IDLE: busy=0; on tick -> SCAN, idx=0.
//  FSM SCAN: busy=1; one button per cycle, idx=0..N_BTN-1, then -> IDLE.
//   A scan therefore lasts exactly N_BTN cycles; tick never lands in SCAN
//   (guaranteed by TICK_DIV > N_BTN+1; no tick queueing required).
//  Per visit of button i (cnt width = $clog2(MAX_BTN_COUNT+1)):
//   - btn_s[i]==out[i]: cnt[i]<=0 (any bounce restarts the count).
//   - btn_s[i]!=out[i] and cnt[i]+1 < MAX_BTN_COUNT: cnt[i]<=cnt[i]+1.
//   - btn_s[i]!=out[i] and cnt[i]+1 == MAX_BTN_COUNT: out[i]<=btn_s[i],
//     cnt[i]<=0; next cycle press[i]=1 if new level 1, else release[i]=1.
//   cnt never exceeds MAX_BTN_COUNT-1; no wrap possible.
//  Strobes: registered, asserted exactly one clk cycle, at most one bit of
//   press|release set per cycle (one button serviced per cycle).
//  Latency: a clean edge is accepted on the MAX_BTN_COUNT-th scan whose
//   sampled value differs from out; worst case
//   2 + MAX_BTN_COUNT*TICK_DIV + N_BTN cycles after the pin edge.
//  Simultaneous edges on several buttons: handled independently; their
//   out flips occur on consecutive cycles of the same scan, in index order.
//  Reset mid-scan: FSM, idx and counters clear immediately; no strobe is
//   emitted; scanning restarts on the first tick after nrst rises.
//  MAX_BTN_COUNT=1: level accepted on first differing sample.
// TESTING (bench params N_BTN=4, TICK_DIV=8, MAX_BTN_COUNT=3)
//  1 Reset: nrst=0 with nbtn=4'b0000 -> out=0,press=0,release=0,busy=0
//    asynchronously; after release first busy pulse 8 cycles later, 4 long.
//  2 Clean press btn0: nbtn[0]=0 held -> out[0]=1 on 3rd scan after sync,
//    press[0]=1 exactly one cycle, release=0, other outs unchanged.
//  3 Bounce: btn1 toggled every 3 cycles for 60 cycles then held pressed ->
//    no press[1] during bounce; out[1]=1 only 3 scans after toggling stops.
//  4 Release: from out[0]=1 set nbtn[0]=1 -> out[0]=0 after 3 scans,
//    release[0] one cycle, press stays 0.
//  5 Simultaneous: nbtn=4'b0000 from idle -> press[0..3] strobe on 4
//    consecutive cycles of one scan, out=4'b1111.
//  6 Reset mid-scan: assert nrst while busy=1 with cnt[2]=2 -> all clear,
//    no strobe; after release btn2 needs 3 fresh scans to be accepted.

Source files
------------

// File: rtl/deb_scan_if.sv
// deb_scan_if: button pins in, debounced levels and strobes out.
// The scanner takes the slave side; application logic takes master.
interface deb_scan_if #(
    parameter int N_BTN = 4
);
    logic [N_BTN-1:0] nbtn_i;
    logic [N_BTN-1:0] out_o;
    logic [N_BTN-1:0] press_o;
    logic [N_BTN-1:0] release_o;
    logic             busy_o;

    modport master (
        output nbtn_i,
        input  out_o,
        input  press_o,
        input  release_o,
        input  busy_o
    );

    modport slave (
        input  nbtn_i,
        output out_o,
        output press_o,
        output release_o,
        output busy_o
    );
endinterface

// File: rtl/deb_scan.sv
// deb_scan: round-robin debounce scheduler; one prescaler and one
// compare/increment path shared by N_BTN active-low buttons.
module deb_scan #(
    parameter int N_BTN         = 4,
    parameter int TICK_DIV      = 12000,
    parameter int MAX_BTN_COUNT = 20
) (
    input logic       clk,
    input logic       nrst,
    deb_scan_if.slave bus
);
    localparam int CW = $clog2(MAX_BTN_COUNT + 1);
    localparam int PW = $clog2(TICK_DIV);
    localparam int IW = (N_BTN > 1) ? $clog2(N_BTN) : 1;

    localparam logic [PW-1:0] PS_LAST  = PW'(TICK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_BTN - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BTN_COUNT - 1);

    typedef enum logic {
        IDLE,
        SCAN
    } state_e;

    state_e state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [PW-1:0] ps_q, ps_d;
    logic tick;
    logic busy;

    logic [N_BTN-1:0] sync1_q, btn_s_q;
    logic [N_BTN-1:0] out_q, out_d;
    logic [N_BTN-1:0] press_q, press_d;
    logic [N_BTN-1:0] rel_q, rel_d;
    logic [CW-1:0] cnt_q [N_BTN];
    logic [CW-1:0] cnt_d [N_BTN];
    logic [CW-1:0] cur;

    // Pins are active-low and asynchronous: invert, then two flops.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync1_q <= '0;
            btn_s_q <= '0;
        end else begin
            sync1_q <= ~bus.nbtn_i;
            btn_s_q <= sync1_q;
        end
    end

    assign tick = (ps_q == PS_LAST);
    assign ps_d = tick ? '0 : ps_q + PW'(1);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = SCAN;
                    idx_d   = '0;
                end
            end
            SCAN: begin
                if (idx_q == IDX_LAST) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        busy = (state_q == SCAN);
    end

    // Shared compare/increment path, applied to the visited button only.
    always_comb begin
        out_d   = out_q;
        press_d = '0;
        rel_d   = '0;
        cnt_d   = cnt_q;
        cur     = cnt_q[idx_q];
        if (busy) begin
            if (btn_s_q[idx_q] == out_q[idx_q]) begin
                cnt_d[idx_q] = '0;
            end else if (cur == CNT_LAST) begin
                cnt_d[idx_q] = '0;
                out_d[idx_q] = btn_s_q[idx_q];
                if (btn_s_q[idx_q]) begin
                    press_d[idx_q] = 1'b1;
                end else begin
                    rel_d[idx_q] = 1'b1;
                end
            end else begin
                cnt_d[idx_q] = cur + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            out_q   <= '0;
            press_q <= '0;
            rel_q   <= '0;
            cnt_q   <= '{default: '0};
        end else begin
            out_q   <= out_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.out_o     = out_q;
    assign bus.press_o   = press_q;
    assign bus.release_o = rel_q;
    assign bus.busy_o    = busy;
endmodule
